// File: rtl/key_pkg.sv
// key_pkg: shared types and default constants for the key debouncer.
//   key_state_t      - debounce FSM state (2 bits)
//   KEY_CNT_MAX_DEF  - default stable-cycle count (20 ms at 50 MHz)
//   KEY_LONG_MAX_DEF - default long-press cycle count (2 s at 50 MHz)
package key_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_FLT   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_FLT = 2'd3
    } key_state_t;

    localparam int unsigned KEY_CNT_MAX_DEF  = 1_000_000;
    localparam int unsigned KEY_LONG_MAX_DEF = 100_000_000;

endpackage : key_pkg

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
//   clk    - destination clock
//   rst_n  - synchronous active-low reset, loads RST_VAL into both flops
//   d      - asynchronous input
//   q      - synchronized output (second flop)
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    // Metastability chain; only s1_q may go metastable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule : sync_2ff

// File: rtl/key_debounce.sv
// key_debounce: mechanical key debouncer with press/release/long-press pulses.
//   clk         - system clock, rising edge
//   rst_n       - synchronous active-low reset
//   key_in      - raw asynchronous key, active-low (0 = pressed)
//   key_level   - debounced level, 1 = pressed (registered)
//   key_press   - one-cycle pulse on accepted press
//   key_release - one-cycle pulse on accepted release
//   key_long    - one-cycle pulse after LONG_MAX pressed cycles
// Build option: define KEY_DEBOUNCE_LONG_PRESS_EN to include the long-press
// counter; otherwise key_long is tied to 0.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX  = KEY_CNT_MAX_DEF,
    parameter int unsigned LONG_MAX = KEY_LONG_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    // Elaboration-time parameter sanity check.
    if (CNT_MAX < 2 || LONG_MAX <= CNT_MAX) begin : g_param_check
        $error("key_debounce: illegal CNT_MAX/LONG_MAX");
    end

    logic       key_s;
    key_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       release_q, release_d;

    // Synchronizer resets to the released level so reset never looks like a press.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_in),
        .q     (key_s)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Next-state: filter states count consecutive stable samples; the last
    // increment (cnt_q == CNT_MAX-1) commits the transition on the same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!key_s) begin
                    state_d = PRESS_FLT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_FLT: begin
                if (key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(CNT_MAX - 1)) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                cnt_d = '0;
                if (key_s) begin
                    state_d = RELEASE_FLT;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_FLT: begin
                if (!key_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(CNT_MAX - 1)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        level_d = (state_d == PRESSED) || (state_d == RELEASE_FLT);
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned LONG_W = $clog2(LONG_MAX + 1);

    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_q, long_d;
    logic              held_now, held_next;

    // Counts edges spent pressed since PRESSED entry; saturates at LONG_MAX.
    always_comb begin
        held_now   = (state_q == PRESSED) || (state_q == RELEASE_FLT);
        held_next  = (state_d == PRESSED) || (state_d == RELEASE_FLT);
        long_cnt_d = '0;
        long_d     = 1'b0;
        if (held_now && held_next) begin
            if (long_cnt_q < LONG_W'(LONG_MAX)) begin
                long_cnt_d = long_cnt_q + LONG_W'(1);
            end else begin
                long_cnt_d = long_cnt_q;
            end
            long_d = (long_cnt_q == LONG_W'(LONG_MAX - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            long_q     <= long_d;
        end
    end

    assign key_long = long_q;
`else
    assign key_long = 1'b0;
`endif

endmodule : key_debounce

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboard bench for key_debounce (CNT_MAX=4, LONG_MAX=10).
// Stimulus pushes expected output events (kind + cycle); a monitor pops and
// compares whenever an output pulse or level change appears.
module tb_key_debounce;

    localparam int unsigned CNT_MAX  = 4;
    localparam int unsigned LONG_MAX = 10;

    typedef enum int {EV_LVL_UP, EV_LVL_DN, EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } ev_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic key_in = 1'b1;
    logic key_level, key_press, key_release, key_long;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    logic prev_level = 1'b0;
    logic prev_press = 1'b0;
    logic prev_release = 1'b0;
    logic prev_long = 1'b0;

    key_debounce #(
        .CNT_MAX  (CNT_MAX),
        .LONG_MAX (LONG_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    // cyc == N at the negedge following rising edge number N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(input ev_kind_t k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // e0 = first edge sampling the new held key value.
    task automatic push_press(input int e0);
        expect_ev(EV_LVL_UP, e0 + 5);
        expect_ev(EV_PRESS, e0 + 5);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        expect_ev(EV_LONG, e0 + 15);
`endif
    endtask

    task automatic push_release(input int e0);
        expect_ev(EV_LVL_DN, e0 + 5);
        expect_ev(EV_RELEASE, e0 + 5);
    endtask

    task automatic observe(input ev_kind_t k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got %s@%0d, required no event", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got %s@%0d, required %s@%0d",
                         k.name(), cyc, e.kind.name(), e.cyc);
            end
        end
    endtask

    // Monitor: compare every observed event and check pulse shape.
    always @(negedge clk) begin
        if (key_level != prev_level) observe(key_level ? EV_LVL_UP : EV_LVL_DN);
        if (key_press)   observe(EV_PRESS);
        if (key_release) observe(EV_RELEASE);
        if (key_long)    observe(EV_LONG);
        if (key_press || key_release || key_long) begin
            checks++;
            if ((key_press && key_release) || (key_press && prev_press) ||
                (key_release && prev_release) || (key_long && prev_long)) begin
                errors++;
                $display("FAIL pulse_shape@%0d: got press=%b rel=%b long=%b (prev %b%b%b), required single-cycle exclusive pulses",
                         cyc, key_press, key_release, key_long, prev_press, prev_release, prev_long);
            end
        end
        prev_level   = key_level;
        prev_press   = key_press;
        prev_release = key_release;
        prev_long    = key_long;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({key_level, key_press, key_release, key_long} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_outs: got %b, required 0000", tag,
                     {key_level, key_press, key_release, key_long});
        end
    endtask

    initial begin
        int e0;

        // Power-on reset
        rst_n  = 1'b0;
        key_in = 1'b1;
        step(3);
        check_zero("por");
        rst_n = 1'b1;
        step(5);

        // Clean press, long hold, clean release
        key_in = 1'b0;
        e0 = cyc + 1;
        push_press(e0);
        step(25);
        key_in = 1'b1;
        e0 = cyc + 1;
        push_release(e0);
        step(12);

        // Press bounce (0,0,1 then 0 held), then a one-cycle release bounce
        key_in = 1'b0;
        step(2);
        key_in = 1'b1;
        step(1);
        key_in = 1'b0;
        e0 = cyc + 1;
        push_press(e0);
        step(8);
        key_in = 1'b1;
        step(1);
        key_in = 1'b0;
        step(20);
        key_in = 1'b1;
        e0 = cyc + 1;
        push_release(e0);
        step(12);

        // Reset for one edge at E3 of a press; key held through it
        key_in = 1'b0;
        e0 = cyc + 1;
        step(3);
        rst_n = 1'b0;
        step(1);
        check_zero("mid_reset");
        rst_n = 1'b1;
        push_press(e0 + 4);
        step(25);
        key_in = 1'b1;
        e0 = cyc + 1;
        push_release(e0);
        step(12);

        // Drain: every expected event must have been observed
        step(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_key_debounce
